// File: rtl/mux_scan_if.sv
// Result handshake between the scan controller and its consumer.
// The controller holds word/word_valid until the consumer raises word_ready.
interface mux_scan_if;
  logic [3:0] word;
  logic       word_valid;
  logic       word_ready;

  modport master (output word, output word_valid, input word_ready);
  modport slave  (input word, input word_valid, output word_ready);
endinterface

// File: rtl/mux_scan_ctrl.sv
// Walks the 4:1 mux select through channels 0..3 and dwells DWELL cycles on each.
// It samples Y at the end of each dwell and hands the 4-bit word downstream.
//
// state  | meaning
// IDLE   | select parked at 00, waiting for start
// SETTLE | channel ch selected, cnt counts dwell cycles, Y captured at terminal count
// HOLD   | word presented with word_valid, waiting for word_ready
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  input  logic  cont,
  input  logic  Y,
  output logic  S0,
  output logic  S1,
  output logic  busy,
  mux_scan_if.master wb
);

  localparam logic [7:0] DWELL_TC = 8'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t      state, state_nxt;
  logic [1:0]  ch, ch_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [2:0]  acc, acc_nxt;
  logic [3:0]  word_q, word_nxt;
  logic        valid_q, valid_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= 2'd0;
      cnt     <= 8'd0;
      acc     <= 3'd0;
      word_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      word_q  <= word_nxt;
      valid_q <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    word_nxt  = word_q;
    valid_nxt = valid_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          ch_nxt    = 2'd0;
          cnt_nxt   = 8'd0;
        end
      end
      SETTLE: begin
        if (cnt == DWELL_TC) begin
          cnt_nxt = 8'd0;
          if (ch == 2'd3) begin
            // Channel 3 goes straight into the word rather than through acc.
            word_nxt  = {Y, acc};
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end else begin
            case (ch)
              2'd0:    acc_nxt[0] = Y;
              2'd1:    acc_nxt[1] = Y;
              default: acc_nxt[2] = Y;
            endcase
            ch_nxt = ch + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      HOLD: begin
        if (valid_q && wb.word_ready) begin
          valid_nxt = 1'b0;
          ch_nxt    = 2'd0;
          cnt_nxt   = 8'd0;
          state_nxt = cont ? SETTLE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy          = (state != IDLE);
  assign {S1, S0}      = (state == SETTLE) ? ch : 2'b00;
  assign wb.word       = word_q;
  assign wb.word_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: three instances (DWELL 2, 1, 255), each fed by a mux4x1 model.
// Directed checks cover timing; per-instance monitors pop expected words on every handshake.
module tb_mux_scan_ctrl;

  logic clk;
  int   errors = 0;
  int   checks = 0;

  logic rst2, start2, cont2, s0_2, s1_2, busy2, y2;
  logic rst1, start1, cont1, s0_1, s1_1, busy1, y1;
  logic rst255, start255, cont255, s0_255, s1_255, busy255, y255;
  logic [3:0] d2, d1, d255;

  logic [3:0] exp2[$];
  logic [3:0] exp1[$];
  logic [3:0] exp255[$];

  mux_scan_if w2();
  mux_scan_if w1();
  mux_scan_if w255();

  assign y2   = d2[{s1_2, s0_2}];
  assign y1   = d1[{s1_1, s0_1}];
  assign y255 = d255[{s1_255, s0_255}];

  mux_scan_ctrl #(.DWELL(2)) u2 (
    .clk(clk), .rst_n(rst2), .start(start2), .cont(cont2), .Y(y2),
    .S0(s0_2), .S1(s1_2), .busy(busy2), .wb(w2));
  mux_scan_ctrl #(.DWELL(1)) u1 (
    .clk(clk), .rst_n(rst1), .start(start1), .cont(cont1), .Y(y1),
    .S0(s0_1), .S1(s1_1), .busy(busy1), .wb(w1));
  mux_scan_ctrl #(.DWELL(255)) u255 (
    .clk(clk), .rst_n(rst255), .start(start255), .cont(cont255), .Y(y255),
    .S0(s0_255), .S1(s1_255), .busy(busy255), .wb(w255));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (w2.word_valid && w2.word_ready) begin
      if (exp2.size() == 0) begin
        checks++; errors++;
        $display("FAIL u2 unexpected word: got %b expected none at %0t", w2.word, $time);
      end else check4("u2 word", w2.word, exp2.pop_front());
    end
    if (w1.word_valid && w1.word_ready) begin
      if (exp1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1 unexpected word: got %b expected none at %0t", w1.word, $time);
      end else check4("u1 word", w1.word, exp1.pop_front());
    end
    if (w255.word_valid && w255.word_ready) begin
      if (exp255.size() == 0) begin
        checks++; errors++;
        $display("FAIL u255 unexpected word: got %b expected none at %0t", w255.word, $time);
      end else check4("u255 word", w255.word, exp255.pop_front());
    end
  end

  initial begin
    rst2 = 0; rst1 = 0; rst255 = 0;
    start2 = 0; start1 = 0; start255 = 0;
    cont2 = 0; cont1 = 0; cont255 = 0;
    w2.word_ready = 1; w1.word_ready = 1; w255.word_ready = 1;
    d2 = 4'b1010; d1 = 4'b1010; d255 = 4'b1000;

    #12;
    check4("reset S", {2'b00, s1_2, s0_2}, 4'b0000);
    check4("reset word", w2.word, 4'b0000);
    check1("reset valid", w2.word_valid, 1'b0);
    check1("reset busy", busy2, 1'b0);
    check1("reset busy u1", busy1, 1'b0);
    rst2 = 1; rst1 = 1; rst255 = 1;
    tick(2);

    // Basic scan, DWELL=2
    exp2.push_back(4'b1010);
    start2 = 1;
    tick(1);
    start2 = 0;
    for (int i = 0; i < 8; i++) begin
      check4("basic select", {2'b00, s1_2, s0_2}, 4'(i / 2));
      check1("basic valid low", w2.word_valid, 1'b0);
      tick(1);
    end
    check1("basic valid", w2.word_valid, 1'b1);
    check4("basic word", w2.word, 4'b1010);
    check4("basic hold select", {2'b00, s1_2, s0_2}, 4'b0000);
    tick(1);
    check1("basic valid drop", w2.word_valid, 1'b0);
    check1("basic busy drop", busy2, 1'b0);
    check4("basic word kept", w2.word, 4'b1010);

    // Backpressure
    w2.word_ready = 0;
    exp2.push_back(4'b1010);
    start2 = 1;
    tick(1);
    start2 = 0;
    tick(8);
    for (int i = 0; i < 5; i++) begin
      check1("bp valid held", w2.word_valid, 1'b1);
      check4("bp word held", w2.word, 4'b1010);
      tick(1);
    end
    w2.word_ready = 1;
    check1("bp valid before ready edge", w2.word_valid, 1'b1);
    tick(1);
    check1("bp valid drop", w2.word_valid, 1'b0);
    check1("bp idle", busy2, 1'b0);

    // Continuous mode, DWELL=1
    cont1 = 1;
    exp1.push_back(4'b1010);
    exp1.push_back(4'b0110);
    start1 = 1;
    tick(1);
    start1 = 0;
    tick(3);
    check1("cont valid early", w1.word_valid, 1'b0);
    tick(1);
    check1("cont first valid", w1.word_valid, 1'b1);
    check4("cont first word", w1.word, 4'b1010);
    d1 = 4'b0110;
    tick(1);
    check1("cont valid drop", w1.word_valid, 1'b0);
    check1("cont busy", busy1, 1'b1);
    check4("cont restart select", {2'b00, s1_1, s0_1}, 4'b0000);
    cont1 = 0;
    tick(3);
    check1("cont second valid early", w1.word_valid, 1'b0);
    tick(1);
    check1("cont second valid", w1.word_valid, 1'b1);
    check4("cont second word", w1.word, 4'b0110);
    tick(1);
    check1("cont stop busy", busy1, 1'b0);

    // Start while busy
    d2 = 4'b0101;
    exp2.push_back(4'b0101);
    start2 = 1;
    tick(1);
    start2 = 0;
    tick(2);
    start2 = 1;
    tick(1);
    start2 = 0;
    tick(4);
    check1("busy-start valid early", w2.word_valid, 1'b0);
    tick(1);
    check1("busy-start valid", w2.word_valid, 1'b1);
    check4("busy-start word", w2.word, 4'b0101);
    tick(1);
    for (int i = 0; i < 6; i++) begin
      check1("busy-start stays idle", busy2, 1'b0);
      tick(1);
    end

    // Reset mid-scan during channel 2
    d2 = 4'b1010;
    start2 = 1;
    tick(1);
    start2 = 0;
    tick(4);
    check4("mid-scan select ch2", {2'b00, s1_2, s0_2}, 4'b0010);
    #2 rst2 = 0;
    #1;
    check4("async rst S", {2'b00, s1_2, s0_2}, 4'b0000);
    check4("async rst word", w2.word, 4'b0000);
    check1("async rst valid", w2.word_valid, 1'b0);
    check1("async rst busy", busy2, 1'b0);
    rst2 = 1;
    tick(1);
    exp2.push_back(4'b1010);
    start2 = 1;
    tick(1);
    start2 = 0;
    tick(8);
    check1("post-reset valid", w2.word_valid, 1'b1);
    check4("post-reset word", w2.word, 4'b1010);
    tick(1);
    check1("post-reset idle", busy2, 1'b0);

    // DWELL=255 edge
    exp255.push_back(4'b1000);
    start255 = 1;
    tick(1);
    start255 = 0;
    tick(1019);
    check1("dwell255 valid early", w255.word_valid, 1'b0);
    check4("dwell255 select ch3", {2'b00, s1_255, s0_255}, 4'b0011);
    tick(1);
    check1("dwell255 valid", w255.word_valid, 1'b1);
    check4("dwell255 word", w255.word, 4'b1000);
    tick(2);
    check1("dwell255 idle", busy255, 1'b0);

    check4("u2 words outstanding", 4'(exp2.size()), 4'd0);
    check4("u1 words outstanding", 4'(exp1.size()), 4'd0);
    check4("u255 words outstanding", 4'(exp255.size()), 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
